// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-754 single-precision divider.
// Restoring mantissa division, 25 quotient bits, truncating rounding,
// denormal operands flushed to zero. Fixed 26-cycle latency for all
// operand classes; ready/valid handshake on both sides.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_iA,
  input  logic [31:0] data_iB,
  input  logic        Valid_In,
  output logic        Ready,
  output logic [31:0] data_o,
  output logic        Valid_Out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;

  // Special-case codes captured at accept so NORM can substitute the result.
  localparam logic [1:0] SP_NONE = 2'd0;
  localparam logic [1:0] SP_NAN  = 2'd1;
  localparam logic [1:0] SP_INF  = 2'd2;
  localparam logic [1:0] SP_ZERO = 2'd3;

  localparam logic [4:0] LAST_ITER = 5'd24;

  logic [1:0]         state;
  logic               signQ;
  logic signed [9:0]  expQ;
  logic [25:0]        rem;
  logic [23:0]        dvsr;
  logic [24:0]        quo;
  logic [4:0]         iter;
  logic [1:0]         spCode;

  logic               remGeq;
  logic [25:0]        remSub;
  logic signed [9:0]  expAdj;
  logic [22:0]        manAdj;
  logic signed [9:0]  expInit;

  // Special cases in priority order: NaN/inf operand, zero divisor, zero dividend.
  function automatic logic [1:0] classify(input logic [7:0] expA, input logic [7:0] expB);
    if (expA == 8'hFF || expB == 8'hFF) return SP_NAN;
    else if (expB == 8'h00)             return SP_INF;
    else if (expA == 8'h00)             return SP_ZERO;
    else                                return SP_NONE;
  endfunction

  // Final result assembly with exponent saturation to infinity or signed zero.
  function automatic logic [31:0] packResult(input logic sgn, input logic signed [9:0] e,
                                             input logic [22:0] man, input logic [1:0] code);
    case (code)
      SP_NAN:  return 32'h7FC0_0000;
      SP_INF:  return {sgn, 8'hFF, 23'd0};
      SP_ZERO: return {sgn, 31'd0};
      default: begin
        if (e >= 10'sd255)     return {sgn, 8'hFF, 23'd0};
        else if (e <= 10'sd0)  return {sgn, 31'd0};
        else                   return {sgn, e[7:0], man};
      end
    endcase
  endfunction

  assign Ready = (state == IDLE);

  // One restoring-division step plus normalisation of the finished quotient.
  always_comb begin
    remGeq  = (rem >= {2'b00, dvsr});
    remSub  = rem - {2'b00, dvsr};
    expAdj  = quo[24] ? expQ : (expQ - 10'sd1);
    manAdj  = quo[24] ? quo[23:1] : quo[22:0];
    expInit = $signed({2'b00, data_iA[30:23]}) - $signed({2'b00, data_iB[30:23]}) + 10'sd127;
  end

  // Control FSM and datapath registers: accept, iterate, normalise/emit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      signQ     <= 1'b0;
      expQ      <= '0;
      rem       <= '0;
      dvsr      <= '0;
      quo       <= '0;
      iter      <= '0;
      spCode    <= SP_NONE;
      data_o    <= '0;
      Valid_Out <= 1'b0;
    end else begin
      Valid_Out <= 1'b0;
      case (state)
        IDLE: begin
          if (Valid_In) begin
            signQ  <= data_iA[31] ^ data_iB[31];
            expQ   <= expInit;
            rem    <= {2'b01, data_iA[22:0]};
            dvsr   <= {1'b1, data_iB[22:0]};
            quo    <= '0;
            iter   <= '0;
            spCode <= classify(data_iA[30:23], data_iB[30:23]);
            state  <= DIV;
          end
        end
        DIV: begin
          if (remGeq) begin
            quo <= {quo[23:0], 1'b1};
            rem <= remSub << 1;
          end else begin
            quo <= {quo[23:0], 1'b0};
            rem <= rem << 1;
          end
          iter <= iter + 5'd1;
          if (iter == LAST_ITER) state <= NORM;
        end
        NORM: begin
          data_o    <= packResult(signQ, expAdj, manAdj, spCode);
          Valid_Out <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
